// File: rtl/oserdes_pkg.sv
// Shared types and elaboration helpers for the soft output serializer.
package oserdes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Beat counter is sized for the widest legal word (10 bits SDR).
    localparam int CNT_W = $clog2(10);

    function automatic int bpc(input string data_rate);
        return (data_rate == "DDR") ? 2 : 1;
    endfunction

    function automatic int nbeats(input int width, input string data_rate);
        return width / bpc(data_rate);
    endfunction

endpackage

// File: rtl/oserdes_tx_lane.sv
// One serializer channel: holding buffer, shift register and registered Q/Q_OE.
module oserdes_tx_lane
    import oserdes_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int BPC      = 2,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             cap_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             oe_i,
    output logic [BPC-1:0]   q_o,
    output logic             q_oe_o
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] sr_q;
    logic [BPC-1:0]   q_q;
    logic             q_oe_q;

    // Data path carries no reset; the controller decides when it is meaningful.
    always_ff @(posedge clk_i) begin
        if (en_i && cap_i) begin
            hold_q <= d_i;
        end
        if (en_i && load_i) begin
            sr_q <= hold_q >> BPC;
        end else if (en_i && run_i) begin
            sr_q <= sr_q >> BPC;
        end
    end

    // Beat 0 goes straight from hold to Q on the load edge, so no gap cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= {BPC{IDLE_BIT}};
            q_oe_q <= 1'b0;
        end else if (en_i) begin
            q_oe_q <= run_i & oe_i;
            if (load_i) begin
                q_q <= hold_q[BPC-1:0];
            end else if (run_i) begin
                q_q <= sr_q[BPC-1:0];
            end else begin
                q_q <= {BPC{IDLE_BIT}};
            end
        end
    end

    assign q_o    = q_q;
    assign q_oe_o = q_oe_q;

endmodule

// File: rtl/oserdes_tx_gearbox.sv
// Multi-channel fabric serializer with holding buffer, underrun flag,
// word realignment and master/slave start bonding.
module oserdes_tx_gearbox
    import oserdes_pkg::*;
#(
    parameter int    WIDTH          = 4,
    parameter int    NUM_CH         = 1,
    parameter string DATA_RATE      = "DDR",
    parameter bit    CHANNEL_MASTER = 1'b1,
    parameter bit    IDLE_BIT       = 1'b0,
    localparam int   BPC            = bpc(DATA_RATE)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [NUM_CH*WIDTH-1:0] D,
    input  logic                    D_VALID,
    output logic                    D_READY,
    input  logic                    LOAD_WORD,
    input  logic                    OE,
    input  logic                    BOND_SYNC_IN,
    output logic                    BOND_SYNC_OUT,
    output logic [NUM_CH*BPC-1:0]   Q,
    output logic [NUM_CH-1:0]       Q_OE,
    output logic                    WORD_START,
    output logic                    UNDERRUN
);

    localparam int NBEATS = nbeats(WIDTH, DATA_RATE);

    if (WIDTH < 3 || WIDTH > 10 || NUM_CH < 1 || NUM_CH > 8 ||
        !(DATA_RATE == "SDR" || DATA_RATE == "DDR") ||
        (DATA_RATE == "DDR" && (WIDTH % 2) != 0)) begin : g_bad_param
        $error("oserdes_tx_gearbox: illegal WIDTH/NUM_CH/DATA_RATE combination");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_vld_q, hold_vld_d;
    logic             rdy_q;
    logic             ur_q, ur_d;
    logic             ws_q;
    logic             load;
    logic             cap;
    logic             last;
    logic             run_nxt;

    assign cap     = D_VALID & rdy_q;
    assign last    = (cnt_q == CNT_W'(NBEATS - 1));
    assign run_nxt = (state_d == RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ur_d       = ur_q;
        load       = 1'b0;
        hold_vld_d = hold_vld_q;
        unique case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (CHANNEL_MASTER || BOND_SYNC_IN) begin
                    load    = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // A realign request behaves like an early word boundary.
                if (LOAD_WORD || last) begin
                    cnt_d = '0;
                    if (hold_vld_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (last) begin
                            ur_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            hold_vld_d = 1'b0;
        end else if (cap) begin
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
            ur_q       <= 1'b0;
            ws_q       <= 1'b0;
        end else if (EN) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_vld_q <= hold_vld_d;
            rdy_q      <= !hold_vld_d;
            ur_q       <= ur_d;
            ws_q       <= load;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        oserdes_tx_lane #(
            .WIDTH    (WIDTH),
            .BPC      (BPC),
            .IDLE_BIT (IDLE_BIT)
        ) u_lane (
            .clk_i  (CLK),
            .rst_i  (RST),
            .en_i   (EN),
            .d_i    (D[c*WIDTH +: WIDTH]),
            .cap_i  (cap),
            .load_i (load),
            .run_i  (run_nxt),
            .oe_i   (OE),
            .q_o    (Q[c*BPC +: BPC]),
            .q_oe_o (Q_OE[c])
        );
    end

    assign D_READY       = rdy_q;
    assign BOND_SYNC_OUT = CHANNEL_MASTER && (state_q == ARM);
    assign WORD_START    = ws_q;
    assign UNDERRUN      = ur_q;

endmodule

// File: tb/tb_oserdes_tx_gearbox.sv
// Directed bench: SDR/DDR streaming tables plus bonding, realign, enable and reset sequences.
module tb_oserdes_tx_gearbox;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // a: SDR W=4 master
    logic       a_en, a_v, a_rdy, a_lw, a_oe, a_sin, a_sout, a_ws, a_ur;
    logic [3:0] a_d;
    logic [0:0] a_q, a_qoe;
    oserdes_tx_gearbox #(.WIDTH(4), .NUM_CH(1), .DATA_RATE("SDR"), .CHANNEL_MASTER(1'b1), .IDLE_BIT(1'b0)) u_a (
        .CLK(CLK), .RST(RST), .EN(a_en), .D(a_d), .D_VALID(a_v), .D_READY(a_rdy),
        .LOAD_WORD(a_lw), .OE(a_oe), .BOND_SYNC_IN(a_sin), .BOND_SYNC_OUT(a_sout),
        .Q(a_q), .Q_OE(a_qoe), .WORD_START(a_ws), .UNDERRUN(a_ur));

    // b: DDR W=8, two channels, master
    logic        b_en, b_v, b_rdy, b_lw, b_oe, b_sin, b_sout, b_ws, b_ur;
    logic [15:0] b_d;
    logic [3:0]  b_q;
    logic [1:0]  b_qoe;
    oserdes_tx_gearbox #(.WIDTH(8), .NUM_CH(2), .DATA_RATE("DDR"), .CHANNEL_MASTER(1'b1), .IDLE_BIT(1'b0)) u_b (
        .CLK(CLK), .RST(RST), .EN(b_en), .D(b_d), .D_VALID(b_v), .D_READY(b_rdy),
        .LOAD_WORD(b_lw), .OE(b_oe), .BOND_SYNC_IN(b_sin), .BOND_SYNC_OUT(b_sout),
        .Q(b_q), .Q_OE(b_qoe), .WORD_START(b_ws), .UNDERRUN(b_ur));

    // m/s: bonded SDR W=4 pair
    logic       m_en, m_v, m_rdy, m_lw, m_oe, m_sin, m_sout, m_ws, m_ur;
    logic [3:0] m_d;
    logic [0:0] m_q, m_qoe;
    oserdes_tx_gearbox #(.WIDTH(4), .NUM_CH(1), .DATA_RATE("SDR"), .CHANNEL_MASTER(1'b1), .IDLE_BIT(1'b0)) u_m (
        .CLK(CLK), .RST(RST), .EN(m_en), .D(m_d), .D_VALID(m_v), .D_READY(m_rdy),
        .LOAD_WORD(m_lw), .OE(m_oe), .BOND_SYNC_IN(m_sin), .BOND_SYNC_OUT(m_sout),
        .Q(m_q), .Q_OE(m_qoe), .WORD_START(m_ws), .UNDERRUN(m_ur));

    logic       s_en, s_v, s_rdy, s_lw, s_oe, s_sout, s_ws, s_ur;
    logic [3:0] s_d;
    logic [0:0] s_q, s_qoe;
    oserdes_tx_gearbox #(.WIDTH(4), .NUM_CH(1), .DATA_RATE("SDR"), .CHANNEL_MASTER(1'b0), .IDLE_BIT(1'b0)) u_s (
        .CLK(CLK), .RST(RST), .EN(s_en), .D(s_d), .D_VALID(s_v), .D_READY(s_rdy),
        .LOAD_WORD(s_lw), .OE(s_oe), .BOND_SYNC_IN(m_sout), .BOND_SYNC_OUT(s_sout),
        .Q(s_q), .Q_OE(s_qoe), .WORD_START(s_ws), .UNDERRUN(s_ur));

    // c: SDR W=6 master for realign / enable / reset sequences
    logic       c_en, c_v, c_rdy, c_lw, c_oe, c_sin, c_sout, c_ws, c_ur;
    logic [5:0] c_d;
    logic [0:0] c_q, c_qoe;
    oserdes_tx_gearbox #(.WIDTH(6), .NUM_CH(1), .DATA_RATE("SDR"), .CHANNEL_MASTER(1'b1), .IDLE_BIT(1'b0)) u_c (
        .CLK(CLK), .RST(RST), .EN(c_en), .D(c_d), .D_VALID(c_v), .D_READY(c_rdy),
        .LOAD_WORD(c_lw), .OE(c_oe), .BOND_SYNC_IN(c_sin), .BOND_SYNC_OUT(c_sout),
        .Q(c_q), .Q_OE(c_qoe), .WORD_START(c_ws), .UNDERRUN(c_ur));

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [3:0]  q;
        logic        ws;
        logic        rdy;
        logic        ur;
        logic        sync;
        logic [1:0]  oe;
    } vec_t;

    vec_t va[8];
    vec_t vb[11];

    initial begin
        // Row i: inputs applied before edge i, expected outputs just after edge i.
        va[0] = '{1'b1, 16'h000B, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        va[1] = '{1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        va[2] = '{1'b0, 16'h0000, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
        va[3] = '{1'b0, 16'h0000, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        va[4] = '{1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        va[5] = '{1'b0, 16'h0000, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        va[6] = '{1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        va[7] = '{1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};

        vb[0]  = '{1'b1, 16'h3CA5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vb[1]  = '{1'b1, 16'h00FF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vb[2]  = '{1'b1, 16'h00FF, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
        vb[3]  = '{1'b1, 16'h00FF, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vb[4]  = '{1'b0, 16'h00FF, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vb[5]  = '{1'b0, 16'h0000, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vb[6]  = '{1'b0, 16'h0000, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
        vb[7]  = '{1'b0, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vb[8]  = '{1'b0, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vb[9]  = '{1'b0, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vb[10] = '{1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};

        RST = 1'b1;
        a_en = 1'b1; a_v = 1'b0; a_d = '0; a_lw = 1'b0; a_oe = 1'b1; a_sin = 1'b0;
        b_en = 1'b1; b_v = 1'b0; b_d = '0; b_lw = 1'b0; b_oe = 1'b1; b_sin = 1'b0;
        m_en = 1'b1; m_v = 1'b0; m_d = '0; m_lw = 1'b0; m_oe = 1'b0; m_sin = 1'b0;
        s_en = 1'b1; s_v = 1'b0; s_d = '0; s_lw = 1'b0; s_oe = 1'b0;
        c_en = 1'b1; c_v = 1'b0; c_d = '0; c_lw = 1'b0; c_oe = 1'b1; c_sin = 1'b0;

        tick();
        chk("rst_a_q", 16'(a_q), 16'h0);
        chk("rst_a_rdy", 16'(a_rdy), 16'h1);
        chk("rst_a_ws", 16'(a_ws), 16'h0);
        chk("rst_a_ur", 16'(a_ur), 16'h0);
        chk("rst_a_sync", 16'(a_sout), 16'h0);
        chk("rst_a_qoe", 16'(a_qoe), 16'h0);
        chk("rst_b_q", 16'(b_q), 16'h0);
        chk("rst_b_rdy", 16'(b_rdy), 16'h1);
        tick();
        RST = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a_v = va[i].v;
            a_d = va[i].d[3:0];
            tick();
            chk($sformatf("sdr_q[%0d]", i), 16'(a_q), 16'(va[i].q[0]));
            chk($sformatf("sdr_ws[%0d]", i), 16'(a_ws), 16'(va[i].ws));
            chk($sformatf("sdr_rdy[%0d]", i), 16'(a_rdy), 16'(va[i].rdy));
            chk($sformatf("sdr_ur[%0d]", i), 16'(a_ur), 16'(va[i].ur));
            chk($sformatf("sdr_sync[%0d]", i), 16'(a_sout), 16'(va[i].sync));
            chk($sformatf("sdr_qoe[%0d]", i), 16'(a_qoe), 16'(va[i].oe[0]));
        end

        for (int i = 0; i < 11; i++) begin
            b_v = vb[i].v;
            b_d = vb[i].d;
            tick();
            chk($sformatf("ddr_q[%0d]", i), 16'(b_q), 16'(vb[i].q));
            chk($sformatf("ddr_ws[%0d]", i), 16'(b_ws), 16'(vb[i].ws));
            chk($sformatf("ddr_rdy[%0d]", i), 16'(b_rdy), 16'(vb[i].rdy));
            chk($sformatf("ddr_ur[%0d]", i), 16'(b_ur), 16'(vb[i].ur));
            chk($sformatf("ddr_sync[%0d]", i), 16'(b_sout), 16'(vb[i].sync));
            chk($sformatf("ddr_qoe[%0d]", i), 16'(b_qoe), 16'(vb[i].oe));
        end

        // Bonded pair: slave fed two cycles ahead of the master.
        s_v = 1'b1; s_d = 4'b0110;
        tick();
        s_v = 1'b0;
        chk("bond_s_q_e0", 16'(s_q), 16'h0);
        tick();
        chk("bond_s_sync_e1", 16'(s_sout), 16'h0);
        chk("bond_s_ws_e1", 16'(s_ws), 16'h0);
        m_v = 1'b1; m_d = 4'b1011;
        tick();
        m_v = 1'b0;
        chk("bond_s_ws_e2", 16'(s_ws), 16'h0);
        chk("bond_m_sync_e2", 16'(m_sout), 16'h0);
        tick();
        chk("bond_m_sync_e3", 16'(m_sout), 16'h1);
        chk("bond_s_ws_e3", 16'(s_ws), 16'h0);
        chk("bond_s_q_e3", 16'(s_q), 16'h0);
        tick();
        chk("bond_m_ws_e4", 16'(m_ws), 16'h1);
        chk("bond_s_ws_e4", 16'(s_ws), 16'h1);
        chk("bond_m_q_e4", 16'(m_q), 16'h1);
        chk("bond_s_q_e4", 16'(s_q), 16'h0);
        chk("bond_m_sync_e4", 16'(m_sout), 16'h0);
        tick();
        chk("bond_m_q_e5", 16'(m_q), 16'h1);
        chk("bond_s_q_e5", 16'(s_q), 16'h1);
        tick();
        chk("bond_m_q_e6", 16'(m_q), 16'h0);
        chk("bond_s_q_e6", 16'(s_q), 16'h1);
        tick();
        chk("bond_m_q_e7", 16'(m_q), 16'h1);
        chk("bond_s_q_e7", 16'(s_q), 16'h0);
        chk("bond_s_sync_e7", 16'(s_sout), 16'h0);
        tick();
        tick();

        // Realign: LOAD_WORD during beat 1 of A with B already held.
        c_v = 1'b1; c_d = 6'b111010;
        tick();
        c_v = 1'b0;
        tick();
        tick();
        chk("lw_a_beat0", 16'(c_q), 16'h0);
        chk("lw_a_ws", 16'(c_ws), 16'h1);
        c_v = 1'b1; c_d = 6'b111001;
        tick();
        c_v = 1'b0;
        chk("lw_a_beat1", 16'(c_q), 16'h1);
        chk("lw_rdy_held", 16'(c_rdy), 16'h0);
        c_lw = 1'b1;
        tick();
        c_lw = 1'b0;
        chk("lw_b_beat0", 16'(c_q), 16'h1);
        chk("lw_b_ws", 16'(c_ws), 16'h1);
        chk("lw_ur", 16'(c_ur), 16'h0);
        chk("lw_rdy", 16'(c_rdy), 16'h1);
        begin
            logic [4:0] rest;
            rest = 5'b11100;
            for (int k = 0; k < 5; k++) begin
                tick();
                chk($sformatf("lw_b_beat%0d", k + 1), 16'(c_q), 16'(rest[k]));
                chk($sformatf("lw_ur_b%0d", k + 1), 16'(c_ur), 16'h0);
            end
        end
        tick();
        chk("lw_end_ur", 16'(c_ur), 16'h1);
        chk("lw_end_q", 16'(c_q), 16'h0);

        // Clock-enable freeze mid-word.
        c_v = 1'b1; c_d = 6'b100110;
        tick();
        c_v = 1'b0;
        tick();
        tick();
        chk("en_beat0", 16'(c_q), 16'h0);
        tick();
        chk("en_beat1", 16'(c_q), 16'h1);
        c_en = 1'b0;
        c_v = 1'b1; c_d = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("en_hold_q%0d", k), 16'(c_q), 16'h1);
            chk($sformatf("en_hold_rdy%0d", k), 16'(c_rdy), 16'h1);
        end
        c_v = 1'b0;
        c_en = 1'b1;
        begin
            logic [4:0] tail;
            tail = 5'b01001;
            for (int k = 0; k < 5; k++) begin
                tick();
                chk($sformatf("en_resume%0d", k), 16'(c_q), 16'(tail[k]));
            end
        end

        // Reset mid-word with a second word waiting in hold.
        c_v = 1'b1; c_d = 6'b111111;
        tick();
        c_v = 1'b0;
        tick();
        tick();
        chk("rst_mid_beat0", 16'(c_q), 16'h1);
        c_v = 1'b1; c_d = 6'b010101;
        tick();
        c_v = 1'b0;
        chk("rst_mid_beat1", 16'(c_q), 16'h1);
        chk("rst_mid_rdy_pre", 16'(c_rdy), 16'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_q", 16'(c_q), 16'h0);
        chk("rst_mid_rdy", 16'(c_rdy), 16'h1);
        chk("rst_mid_ur", 16'(c_ur), 16'h0);
        chk("rst_mid_qoe", 16'(c_qoe), 16'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_after_q%0d", k), 16'(c_q), 16'h0);
            chk($sformatf("rst_after_ws%0d", k), 16'(c_ws), 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/oserdes_tx_gearbox.md
Name: oserdes_tx_gearbox

Overview:
- Parametrised, multi-channel soft output serializer running entirely in the fabric clock domain.
- Accepts one parallel word per channel through a valid/ready handshake and emits BPC bits per channel per CLK cycle.
  - BPC = 1 for SDR; BPC = 2 for DDR, which feeds a DDR output cell.
- Adds behaviour the fixed O_SERDES primitive lacks:
  - generic WIDTH and channel count;
  - back-to-back streaming with a holding buffer;
  - underrun detection;
  - word realignment;
  - master/slave bonding across instances.

Parameters:
- WIDTH, 4, bits per word per channel; legal 3..10. DDR requires an even WIDTH; an illegal value is an elaboration error.
- NUM_CH, 1, number of lock-stepped channels; legal 1..8.
- DATA_RATE, "DDR", "SDR" or "DDR".
- CHANNEL_MASTER, 1, 1 = drives BOND_SYNC_OUT; 0 = waits for BOND_SYNC_IN.
- IDLE_BIT, 0, level driven on every Q bit when not streaming.

Ports:
- CLK  in  1  fabric clock.
- RST  in  1  synchronous active-high reset.
- EN  in  1  clock enable. When 0, all state holds; RST overrides EN.
- D  in  NUM_CH*WIDTH  parallel words; channel c occupies D[c*WIDTH +: WIDTH].
- D_VALID  in  1  word available.
- D_READY  out  1  holding buffer empty. This is a registered output, with no combinational path from D_VALID.
- LOAD_WORD  in  1  realign request.
- OE  in  1  output-enable request.
- BOND_SYNC_IN  in  1  start strobe from the bond master; ignored when CHANNEL_MASTER=1.
- BOND_SYNC_OUT  out  1  start strobe to slaves; constant 0 when CHANNEL_MASTER=0.
- Q  out  NUM_CH*BPC  serial data. Q[c*BPC] is the earlier bit and Q[c*BPC+1] the later (DDR only).
- Q_OE  out  NUM_CH  registered copy of OE, gated by RUN.
- WORD_START  out  1  high during the cycle Q carries beat 0 of a word.
- UNDERRUN  out  1  sticky; cleared only by RST.

Behaviour:
- Reset state:
  - state = IDLE, cnt = 0, hold empty;
  - D_READY = 1 from the first cycle after reset;
  - Q = IDLE_BIT on all bits, Q_OE = 0, WORD_START = 0, BOND_SYNC_OUT = 0, UNDERRUN = 0.
- RST mid-word aborts immediately and drops the remaining bits and the held word.
- Handshake:
  - D is captured into hold on an edge where D_VALID & D_READY & EN.
  - D_READY = !hold_valid.
  - Hold empties on the edge where it is loaded into the shift register.
  - NBEATS = WIDTH/BPC (≥ 2), so gapless streaming is sustained.
- Serialization:
  - LSB first.
  - Each RUN cycle shifts BPC bits per channel. Q is registered and shows beat k in cycle load+1+k.
- State machine (one shared controller):
  - IDLE → ARM when hold_valid.
  - ARM, master: BOND_SYNC_OUT = 1 for exactly this cycle; the next edge loads hold, sets cnt = 0, and goes to RUN.
  - ARM, slave: waits; loads and goes to RUN on the edge where BOND_SYNC_IN = 1. A sync pulse seen outside ARM is ignored.
  - RUN: cnt increments every enabled cycle. At cnt = NBEATS-1:
    - if hold_valid, load the next word, cnt = 0, stay in RUN;
    - otherwise go to IDLE and set UNDERRUN.
- Latency (master): D accepted at edge 0 → ARM after edge 1 → load at edge 2 → beat 0 on Q in cycle 3.
- LOAD_WORD in RUN:
  - the current word is abandoned at that edge;
  - if hold_valid, load hold with cnt = 0; otherwise go to IDLE without setting UNDERRUN;
  - simultaneous with a natural boundary, the result is identical.
- LOAD_WORD in IDLE or ARM is ignored.
- Q_OE[c] = OE registered while in RUN, else 0. Q = IDLE_BIT whenever not in RUN.
- EN = 0: counter, shift register, Q and hold all freeze; D_READY still reflects hold.

Decomposition:
- Package oserdes_pkg holds:
  - state enum {IDLE, ARM, RUN};
  - function bpc(DATA_RATE);
  - function nbeats(WIDTH, DATA_RATE);
  - counter width constant (clog2 of 10).
- Sub-module oserdes_tx_lane, one instance per channel:
  - contains the WIDTH-bit hold register, shift register and Q/Q_OE registers;
  - driven by load/shift strobes from the top-level controller.

Test Plan:
- SDR, WIDTH=4, NUM_CH=1, master: D=4'b1011 with a single-cycle D_VALID at edge 0 → Q = 1,1,0,1 in cycles 3-6; WORD_START high in cycle 3 only; then UNDERRUN = 1 and Q = 0.
- DDR, WIDTH=8, NUM_CH=2, D_VALID held high with words 0xA5/0x3C then 0xFF/0x00 → for channel 0, Q[1:0] = 01,01,10,10 then 11 ×4, with no gap cycle; UNDERRUN stays 0 while the stream continues; D_READY toggles once per word.
- Bonded pair, with the master's BOND_SYNC_OUT wired to the slave's BOND_SYNC_IN and the slave fed 2 cycles early → both first emit beat 0 in the same cycle; the slave's ARM lasts until the master's sync pulse.
- LOAD_WORD pulsed at beat 1 of a WIDTH=6 SDR word with the next word held → the next word's beat 0 appears in the following cycle; UNDERRUN stays 0.
- EN low for 3 cycles mid-word → Q holds its value; the sequence resumes unchanged.
- RST asserted mid-word → the next cycle shows Q = IDLE_BIT, D_READY = 1 and UNDERRUN = 0.
